// File: rtl/alu_responder.sv
// alu_responder: single-outstanding ALU behind valid/ready request and response handshakes.
// Shifts iterate one bit per cycle. All other operations respond in the cycle after accept.
module alu_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  aluop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_t;

  state_t      state, state_next;
  shift_t      kind, kind_in;
  logic [31:0] work, step, alu_res;
  logic [4:0]  count;
  logic        alu_err, is_shift, accept;

  // One-shot result for the non-iterating ops; a zero-length shift simply returns a.
  always_comb begin
    alu_res  = '0;
    alu_err  = 1'b0;
    is_shift = 1'b0;
    kind_in  = SH_LL;
    case (aluop)
      4'b0000: alu_res = a & b;
      4'b0001: alu_res = a | b;
      4'b0010: alu_res = a + b;
      4'b0011: alu_res = a ^ b;
      4'b0100: alu_res = ~(a | b);
      4'b0110: alu_res = a - b;
      4'b0111: alu_res = {31'd0, $signed(a) < $signed(b)};
      4'b1000: begin is_shift = 1'b1; alu_res = a; kind_in = SH_LL; end
      4'b1001: begin is_shift = 1'b1; alu_res = a; kind_in = SH_RL; end
      4'b1010: begin is_shift = 1'b1; alu_res = a; kind_in = SH_RA; end
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    case (kind)
      SH_RL:   step = {1'b0, work[31:1]};
      SH_RA:   step = {work[31], work[31:1]};
      default: step = {work[30:0], 1'b0};
    endcase
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_next = (is_shift && b[4:0] != 5'd0) ? SHIFT : RESP;
      end
      SHIFT: if (count == 5'd1) state_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;
  assign zero   = (result == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // result is only written on entry to RESP, so it and zero stay frozen while a response waits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result  <= '0;
      rsp_err <= 1'b0;
      work    <= '0;
      count   <= '0;
      kind    <= SH_LL;
    end else begin
      case (state)
        IDLE: if (accept) begin
          rsp_err <= alu_err;
          if (is_shift && b[4:0] != 5'd0) begin
            work  <= a;
            count <= b[4:0];
            kind  <= kind_in;
          end else begin
            result <= alu_res;
          end
        end
        SHIFT: begin
          work  <= step;
          count <= count - 5'd1;
          if (count == 5'd1) result <= step;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_responder.sv
// Self-checking bench for alu_responder: directed corner cases plus randomized operations
// compared against an operator-level reference model with expected latency.
module tb_alu_responder;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, rsp_valid, rsp_ready, zero, rsp_err;
  logic [3:0]  aluop;
  logic [31:0] a, b, result;
  int unsigned vectors = 0;
  int unsigned errors  = 0;

  always #5 clk = ~clk;

  alu_responder dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .aluop(aluop), .a(a), .b(b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .result(result), .zero(zero), .rsp_err(rsp_err)
  );

  function automatic void ref_model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] res, output logic err, output int lat);
    logic [4:0] sh;
    sh  = y[4:0];
    err = 1'b0;
    lat = 1;
    case (op)
      4'd0:    res = x & y;
      4'd1:    res = x | y;
      4'd2:    res = x + y;
      4'd3:    res = x ^ y;
      4'd4:    res = ~(x | y);
      4'd6:    res = x - y;
      4'd7:    res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd8:    res = x << sh;
      4'd9:    res = x >> sh;
      4'd10:   res = $unsigned($signed(x) >>> sh);
      default: begin res = '0; err = 1'b1; end
    endcase
    if (op inside {4'd8, 4'd9, 4'd10}) lat = 1 + int'(sh);
  endfunction

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input int hold);
    logic [31:0] exp_res;
    logic        exp_err;
    int          exp_lat, lat;
    ref_model(op, x, y, exp_res, exp_err, exp_lat);
    @(negedge clk);
    req_valid = 1'b1; aluop = op; a = x; b = y;
    vectors++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL %s req_ready_idle: got %b want 1", name, req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; aluop = 4'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      vectors++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL %s req_ready_busy: got %b want 0", name, req_ready); end
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (lat != exp_lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
    vectors++;
    if (result !== exp_res) begin errors++; $display("FAIL %s result: got %h want %h", name, result, exp_res); end
    vectors++;
    if (zero !== (exp_res == 32'd0)) begin errors++; $display("FAIL %s zero: got %b want %b", name, zero, exp_res == 32'd0); end
    vectors++;
    if (rsp_err !== exp_err) begin errors++; $display("FAIL %s rsp_err: got %b want %b", name, rsp_err, exp_err); end
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'($urandom);
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || result !== exp_res ||
          zero !== (exp_res == 32'd0) || rsp_err !== exp_err) begin
        errors++;
        $display("FAIL %s hold[%0d]: got v=%b r=%b res=%h z=%b e=%b want v=1 r=0 res=%h e=%b",
                 name, i, rsp_valid, req_ready, result, zero, rsp_err, exp_res, exp_err);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL %s after_transfer: got v=%b r=%b want v=0 r=1", name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; aluop = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_handshake: got r=%b v=%b want r=1 v=0", req_ready, rsp_valid);
    end
    vectors++;
    if (result !== 32'd0 || zero !== 1'b1 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got res=%h z=%b e=%b want 0 1 0", result, zero, rsp_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_directed;
    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op("slt_neg",  4'b0111, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("slt_pos",  4'b0111, 32'h0000_0001, 32'hFFFF_FFFE, 0);
    run_op("sra_4",    4'b1010, 32'h8000_0000, 32'h0000_0004, 1);
    run_op("sll_32",   4'b1000, 32'hDEAD_BEEF, 32'h0000_0020, 0);
    run_op("srl_31",   4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("nor",      4'b0100, 32'h0F0F_0000, 32'h0000_F0F0, 0);
    run_op("illegal",  4'b1111, 32'h1234_5678, 32'h0000_0000, 0);
    run_op("or_after", 4'b0001, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 0);
  endtask

  task automatic test_backpressure;
    run_op("sub_hold10", 4'b0110, 32'd5, 32'd5, 10);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    req_valid = 1'b1; aluop = 4'b0011; a = 32'h0000_00FF; b = 32'h0000_000F;
    @(posedge clk);
    @(negedge clk);
    aluop = 4'b0010; a = 32'd100; b = 32'd23;
    rsp_ready = 1'b1;
    vectors++;
    if (rsp_valid !== 1'b1 || result !== 32'h0000_00F0) begin
      errors++; $display("FAIL b2b_first: got v=%b res=%h want v=1 res=000000f0", rsp_valid, result);
    end
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_no_early_accept: got v=%b r=%b want v=0 r=1", rsp_valid, req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b1 || result !== 32'd123) begin
      errors++; $display("FAIL b2b_second: got v=%b res=%0d want v=1 res=123", rsp_valid, result);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift;
    bit seen;
    @(negedge clk);
    req_valid = 1'b1; aluop = 4'b1001; a = 32'hFFFF_FFFF; b = 32'd31;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1) begin
      errors++; $display("FAIL reset_mid_shift_state: got r=%b v=%b res=%h z=%b want r=1 v=0 res=0 z=1",
                         req_ready, rsp_valid, result, zero);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    vectors++;
    if (seen) begin errors++; $display("FAIL reset_mid_shift_no_rsp: got rsp_valid=1 want never"); end
  endtask

  task automatic test_reset_in_resp;
    @(negedge clk);
    req_valid = 1'b1; aluop = 4'b0001; a = 32'h0000_00A5; b = '0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b1; aluop = 4'b0010; a = 32'd1; b = 32'd1;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b0; req_valid = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || result !== 32'd0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_in_resp: got v=%b r=%b res=%h e=%b want v=0 r=1 res=0 e=0",
                         rsp_valid, req_ready, result, rsp_err);
    end
  endtask

  task automatic test_random;
    logic [3:0]  op;
    logic [31:0] x, y;
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom);
      x  = $urandom;
      y  = $urandom;
      if ($urandom_range(3, 0) == 0) x = '0;
      if ($urandom_range(3, 0) == 0) y = {27'($urandom), 5'($urandom_range(3, 0))};
      run_op("random", op, x, y, int'($urandom_range(3, 0)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    test_reset_in_resp();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
